uart_tx: RTL and testbench

//  8N1 UART transmitter; transmit-side partner of the uart_rx block. 12 MHz clk, 1 Mbaud default.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_if.sv | 16 +
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default timing and frame geometry.
// Imported by uart_tx and its sub-modules; uart_rx imports the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // 12 MHz system clock at 1 Mbaud.
  localparam int unsigned UART_CLKS_PER_BIT_12M_1M = 12;
  localparam int unsigned UART_DATA_BITS           = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the host/debug link logic and the UART transmitter.
//   data  : byte to send, sampled only on the accept cycle
//   valid : data is valid
//   ready : transmitter can take a byte this cycle (accept = valid & ready)
// master = byte producer, slave = uart_tx.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter for the UART transmitter.
//   clk  : system clock
//   rst  : asynchronous active-high reset (count returns to 0)
//   load : restart the period (count = CLKS_PER_BIT-1)
//   tick : combinational, high while the count is 0 (last cycle of a period)
// The counter never wraps: it decrements only while nonzero and rests at 0.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: reload wins over the free-running decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(CLKS_PER_BIT - 1);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (1 or 2 stop bits), LSB first, 12 MHz / 1 Mbaud default.
//   clk     : system clock
//   rst     : asynchronous active-high reset; abandons any frame, tx high at once
//   bus     : uart_tx_if.slave byte handshake (data, valid, ready)
//             ready is combinational: high in IDLE and in the last cycle of the
//             last stop bit, so streamed bytes go out with no idle gap
//   tx      : registered serial line, idles high
//   busy    : registered, high while a frame is in progress
//   crc_din : data bit for a serial CRC engine
//   crc_en  : one-cycle strobe on the first cycle each data bit drives tx
// Build option: define UART_TX_CRC_EN to generate crc_en/crc_din; otherwise
// both are tied low.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_12M_1M,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_if.slave      bus,
  output logic          tx,
  output logic          busy,
  output logic          crc_din,
  output logic          crc_en
);

  localparam int unsigned BIT_W = 3;

  uart_state_t               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]          bitcnt_q, bitcnt_d;
  logic                      tx_q, tx_d;
  logic                      busy_q;
  logic                      ready_c;
  logic                      load;
  logic                      tick;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .tick (tick)
  );

  // Next-state, shift register and next tx level.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    load     = 1'b0;
    ready_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        tx_d    = 1'b1;
        if (bus.valid) begin
          shift_d = bus.data;
          load    = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          load     = 1'b1;
          bitcnt_d = BIT_W'(UART_DATA_BITS - 1);
          tx_d     = shift_q[0];
          state_d  = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          load = 1'b1;
          if (bitcnt_q == '0) begin
            bitcnt_d = BIT_W'(STOP_BITS - 1);
            tx_d     = 1'b1;
            state_d  = STOP;
          end else begin
            bitcnt_d = bitcnt_q - BIT_W'(1);
            shift_d  = shift_q >> 1;
            // Next bit is shift_q[1], i.e. bit 0 after this shift.
            tx_d     = shift_q[1];
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (bitcnt_q == '0) begin
            // Last cycle of the frame: accepting here chains the next start bit.
            ready_c = 1'b1;
            if (bus.valid) begin
              shift_d = bus.data;
              load    = 1'b1;
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitcnt_d = bitcnt_q - BIT_W'(1);
            load     = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.ready = ready_c;
  assign tx        = tx_q;
  assign busy      = busy_q;

`ifdef UART_TX_CRC_EN
  logic crc_en_q, crc_en_d;
  logic crc_din_q, crc_din_d;

  // Strobe on every transition onto a data bit; crc_din mirrors that bit.
  always_comb begin
    crc_en_d  = 1'b0;
    crc_din_d = 1'b0;
    if (tick && ((state_q == START) || ((state_q == DATA) && (bitcnt_q != '0)))) begin
      crc_en_d  = 1'b1;
      crc_din_d = tx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_en_q  <= 1'b0;
      crc_din_q <= 1'b0;
    end else begin
      crc_en_q  <= crc_en_d;
      crc_din_q <= crc_din_d;
    end
  end

  assign crc_en  = crc_en_q;
  assign crc_din = crc_din_q;
`else
  assign crc_en  = 1'b0;
  assign crc_din = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: one-stop-bit and two-stop-bit instances, frame traces
// checked against a bit-time model, random loopback through a sampling receiver.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = int'(UART_CLKS_PER_BIT_12M_1M);

  typedef logic [511:0] vec_t;
  typedef logic [7:0]   byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  int         dsel;
  logic       drv_valid;
  logic [7:0] drv_data;
  int         n_checks;
  int         n_pass;

  logic tx1, busy1, din1, en1;
  logic tx2, busy2, din2, en2;
  logic cur_tx, cur_ready, cur_busy, cur_en, cur_din;

  always #5 clk = ~clk;

  uart_tx_if if1 ();
  uart_tx_if if2 ();

  assign if1.valid = (dsel == 0) && drv_valid;
  assign if1.data  = drv_data;
  assign if2.valid = (dsel == 1) && drv_valid;
  assign if2.data  = drv_data;

  uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .tx(tx1), .busy(busy1), .crc_din(din1), .crc_en(en1)
  );

  uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave),
    .tx(tx2), .busy(busy2), .crc_din(din2), .crc_en(en2)
  );

  always_comb begin
    if (dsel == 0) begin
      cur_tx = tx1; cur_ready = if1.ready; cur_busy = busy1; cur_en = en1; cur_din = din1;
    end else begin
      cur_tx = tx2; cur_ready = if2.ready; cur_busy = busy2; cur_en = en2; cur_din = din2;
    end
  end

  // Reference: bytes sent back to back from sample 0, frame = start, 8 data LSB first, s stop bits.
  task automatic model_stream(input byte_q_t q, input int s, input int t_len,
                              output vec_t etx, output vec_t erdy, output vec_t ebusy,
                              output vec_t een, output vec_t edin);
    int   l, m, k, p, b;
    logic lvl;
    l = N * (9 + s);
    m = q.size();
    etx = '0; erdy = '0; ebusy = '0; een = '0; edin = '0;
    for (int t = 0; t < t_len; t++) begin
      if (t < m * l) begin
        k = t / l; p = t % l; b = p / N;
        if (b == 0) lvl = 1'b0;
        else if (b <= 8) lvl = q[k][b-1];
        else lvl = 1'b1;
        etx[t]   = lvl;
        ebusy[t] = 1'b1;
        erdy[t]  = (p == l - 1);
`ifdef UART_TX_CRC_EN
        if (b >= 1 && b <= 8 && (p % N) == 0) begin
          een[t]  = 1'b1;
          edin[t] = lvl;
        end
`endif
      end else begin
        etx[t]  = 1'b1;
        erdy[t] = 1'b1;
      end
    end
  endtask

  // Hold valid and present each byte until accepted; record one sample per cycle.
  task automatic run_stream(input byte_q_t q, input int t_len,
                            output vec_t otx, output vec_t ordy, output vec_t obusy,
                            output vec_t oen, output vec_t odin);
    int   idx;
    logic acc;
    otx = '0; ordy = '0; obusy = '0; oen = '0; odin = '0;
    idx = 0;
    drv_data  = q[0];
    drv_valid = 1'b1;
    for (int t = 0; t < t_len; t++) begin
      acc = drv_valid && cur_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < q.size()) drv_data = q[idx];
        else begin drv_valid = 1'b0; drv_data = 8'h00; end
      end
      otx[t] = cur_tx; ordy[t] = cur_ready; obusy[t] = cur_busy;
      oen[t] = cur_en; odin[t] = cur_din;
    end
    drv_valid = 1'b0;
  endtask

  task automatic select_dut(input int s);
    dsel = s;
    drv_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [49:0] vtx, vrdy, vbusy, ven;
    rst = 1'b1; drv_valid = 1'b0; dsel = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({tx1, if1.ready, busy1, en1, din1} !== 5'b11000)
      $display("FAIL reset_dut1 got %b want 11000", {tx1, if1.ready, busy1, en1, din1});
    else n_pass++;
    n_checks++;
    if ({tx2, if2.ready, busy2, en2, din2} !== 5'b11000)
      $display("FAIL reset_dut2 got %b want 11000", {tx2, if2.ready, busy2, en2, din2});
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      vtx[c] = cur_tx; vrdy[c] = cur_ready; vbusy[c] = cur_busy; ven[c] = cur_en;
    end
    n_checks++;
    if (vtx !== {50{1'b1}}) $display("FAIL idle_tx got %h want %h", vtx, {50{1'b1}}); else n_pass++;
    n_checks++;
    if (vrdy !== {50{1'b1}}) $display("FAIL idle_ready got %h want %h", vrdy, {50{1'b1}}); else n_pass++;
    n_checks++;
    if (vbusy !== 50'h0) $display("FAIL idle_busy got %h want 0", vbusy); else n_pass++;
    n_checks++;
    if (ven !== 50'h0) $display("FAIL idle_crc_en got %h want 0", ven); else n_pass++;
  endtask

  task automatic test_single();
    byte_q_t q;
    vec_t etx, erdy, ebusy, een, edin, otx, ordy, obusy, oen, odin;
    int   t_len;
    select_dut(0);
    t_len = N * 10 + 6;
    for (int f = 0; f < 4; f++) begin
      q = {};
      q.push_back((f == 0) ? 8'hA5 : 8'($urandom));
      model_stream(q, 1, t_len, etx, erdy, ebusy, een, edin);
      run_stream(q, t_len, otx, ordy, obusy, oen, odin);
      n_checks++;
      if (otx !== etx) $display("FAIL single_tx byte %h got %h want %h", q[0], otx, etx); else n_pass++;
      n_checks++;
      if (ordy !== erdy) $display("FAIL single_ready byte %h got %h want %h", q[0], ordy, erdy); else n_pass++;
      n_checks++;
      if (obusy !== ebusy) $display("FAIL single_busy byte %h got %h want %h", q[0], obusy, ebusy); else n_pass++;
      n_checks++;
      if (oen !== een) $display("FAIL single_crc_en byte %h got %h want %h", q[0], oen, een); else n_pass++;
      n_checks++;
      if (odin !== edin) $display("FAIL single_crc_din byte %h got %h want %h", q[0], odin, edin); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t q;
    vec_t etx, erdy, ebusy, een, edin, otx, ordy, obusy, oen, odin;
    int   s, t_len;
    for (int sel = 0; sel < 2; sel++) begin
      select_dut(sel);
      s = sel + 1;
      q = {};
      if (sel == 0) begin
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55);
      end else begin
        for (int j = 0; j < 3; j++) q.push_back(8'($urandom));
      end
      t_len = 3 * N * (9 + s) + 6;
      model_stream(q, s, t_len, etx, erdy, ebusy, een, edin);
      run_stream(q, t_len, otx, ordy, obusy, oen, odin);
      n_checks++;
      if (otx !== etx) $display("FAIL b2b_tx stop%0d got %h want %h", s, otx, etx); else n_pass++;
      n_checks++;
      if (ordy !== erdy) $display("FAIL b2b_ready stop%0d got %h want %h", s, ordy, erdy); else n_pass++;
      n_checks++;
      if (obusy !== ebusy) $display("FAIL b2b_busy stop%0d got %h want %h", s, obusy, ebusy); else n_pass++;
      n_checks++;
      if (oen !== een) $display("FAIL b2b_crc_en stop%0d got %h want %h", s, oen, een); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t q;
    vec_t etx, erdy, ebusy, een, edin, otx, ordy, obusy, oen, odin;
    int   t_len;
    select_dut(0);
    q = {};
    q.push_back(8'h3C);
    model_stream(q, 1, 41, etx, erdy, ebusy, een, edin);
    drv_data = 8'h3C; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if ({cur_tx, cur_busy, cur_ready} !== {etx[40], 1'b1, 1'b0})
      $display("FAIL midframe_before got %b want %b", {cur_tx, cur_busy, cur_ready}, {etx[40], 1'b1, 1'b0});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cur_tx, cur_busy, cur_ready, cur_en} !== 4'b1010)
      $display("FAIL midframe_in_reset got %b want 1010", {cur_tx, cur_busy, cur_ready, cur_en});
    else n_pass++;
    drv_valid = 1'b1; drv_data = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({cur_tx, cur_busy, cur_ready} !== 3'b101)
      $display("FAIL midframe_after got %b want 101", {cur_tx, cur_busy, cur_ready});
    else n_pass++;
    q = {};
    q.push_back(8'h81);
    t_len = N * 10 + 6;
    model_stream(q, 1, t_len, etx, erdy, ebusy, een, edin);
    run_stream(q, t_len, otx, ordy, obusy, oen, odin);
    n_checks++;
    if (otx !== etx) $display("FAIL post_reset_tx got %h want %h", otx, etx); else n_pass++;
    n_checks++;
    if (ordy !== erdy) $display("FAIL post_reset_ready got %h want %h", ordy, erdy); else n_pass++;
    n_checks++;
    if (obusy !== ebusy) $display("FAIL post_reset_busy got %h want %h", obusy, ebusy); else n_pass++;
  endtask

  task automatic test_crc();
    byte_q_t    q;
    vec_t       etx, erdy, ebusy, een, edin, otx, ordy, obusy, oen, odin;
    int         t_len, pulses, exp_pulses;
    logic [7:0] seq, exp_seq;
`ifdef UART_TX_CRC_EN
    exp_pulses = 8; exp_seq = 8'hC3;
`else
    exp_pulses = 0; exp_seq = 8'h00;
`endif
    select_dut(0);
    q = {};
    q.push_back(8'hC3);
    t_len = N * 10 + 6;
    model_stream(q, 1, t_len, etx, erdy, ebusy, een, edin);
    run_stream(q, t_len, otx, ordy, obusy, oen, odin);
    pulses = 0; seq = 8'h00;
    for (int t = 0; t < t_len; t++) begin
      if (oen[t] === 1'b1) begin
        if (pulses < 8) seq[pulses] = odin[t];
        pulses++;
      end
    end
    n_checks++;
    if (pulses != exp_pulses) $display("FAIL crc_pulse_count got %0d want %0d", pulses, exp_pulses); else n_pass++;
    n_checks++;
    if (seq !== exp_seq) $display("FAIL crc_din_sequence got %b want %b (LSB first)", seq, exp_seq); else n_pass++;
    n_checks++;
    if (oen !== een) $display("FAIL crc_en_timing got %h want %h", oen, een); else n_pass++;
    n_checks++;
    if (odin !== edin) $display("FAIL crc_din_timing got %h want %h", odin, edin); else n_pass++;
  endtask

  // Random bytes with random gaps and junk on the bus while ready is low;
  // the tx trace is decoded afterwards by mid-bit sampling.
  task automatic test_loopback(input int sel, input int s, input int count);
    byte_q_t    q, rx;
    logic       tr[$];
    logic [7:0] b;
    logic       acc, done;
    int         idx, gap, accepts, budget, ferr, i, span;
    for (int j = 0; j < count; j++) q.push_back(8'($urandom));
    select_dut(sel);
    idx = 0; gap = 0; accepts = 0; done = 1'b0;
    budget = count * N * (13 + s) + 200;
    for (int c = 0; c < budget && !done; c++) begin
      if (cur_ready) begin
        if (idx < count && gap == 0) begin
          drv_valid = 1'b1; drv_data = q[idx];
        end else begin
          drv_valid = 1'b0; drv_data = 8'($urandom);
          if (gap > 0) gap--;
        end
      end else begin
        drv_valid = 1'($urandom); drv_data = 8'($urandom);
      end
      acc = drv_valid && cur_ready;
      @(posedge clk); #1;
      if (acc) begin accepts++; idx++; gap = $urandom_range(0, 3); end
      tr.push_back(cur_tx);
      if (idx == count && !cur_busy) done = 1'b1;
    end
    drv_valid = 1'b0;
    n_checks++;
    if (!done) $display("FAIL loopback_timeout stop%0d sent %0d of %0d", s, idx, count); else n_pass++;

    ferr = 0; i = 0;
    span = N * (8 + s) + N / 2;
    while (i < tr.size()) begin
      if (tr[i] == 1'b0) begin
        if (i + span >= tr.size()) begin ferr++; break; end
        if (tr[i + N / 2] !== 1'b0) ferr++;
        for (int j = 0; j < 8; j++) b[j] = tr[i + N * (1 + j) + N / 2];
        for (int j = 0; j < s; j++) if (tr[i + N * (9 + j) + N / 2] !== 1'b1) ferr++;
        rx.push_back(b);
        i = i + span;
      end else begin
        i++;
      end
    end
    n_checks++;
    if (accepts != count) $display("FAIL loopback_accepts stop%0d got %0d want %0d", s, accepts, count); else n_pass++;
    n_checks++;
    if (ferr != 0) $display("FAIL loopback_framing stop%0d got %0d errors want 0", s, ferr); else n_pass++;
    n_checks++;
    if (rx.size() != count) $display("FAIL loopback_count stop%0d got %0d want %0d", s, rx.size(), count); else n_pass++;
    for (int j = 0; j < count && j < rx.size(); j++) begin
      n_checks++;
      if (rx[j] !== q[j]) $display("FAIL loopback_byte stop%0d idx %0d got %h want %h", s, j, rx[j], q[j]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    dsel      = 0;
    drv_valid = 1'b0;
    drv_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_crc();
    test_loopback(0, 1, 256);
    test_loopback(1, 2, 256);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
